// File: rtl/hazard_unit_param.sv
// Hazard unit for the 5-stage MIPS pipeline with per-class stall lengths and multi-cycle sequencing.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_unit_param #(
  parameter int unsigned REG_ADDR_W    = 5,
  parameter int unsigned LOADUSE_STALL = 1,
  parameter int unsigned BR_ALU_STALL  = 1,
  parameter int unsigned BR_LOAD_STALL = 2,
  parameter int unsigned STAT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branching,
  input  logic                  id_branch,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  flush,
  output logic                  wen,
  output logic                  delay,
  output logic [1:0]            stall_src,
  output logic [STAT_W-1:0]     stall_cycles,
  output logic [STAT_W-1:0]     flush_count
);

  localparam int unsigned BR_MEM_STALL = (BR_LOAD_STALL >= 1) ? 1 : 0;
  localparam int unsigned MAX_LB       = (LOADUSE_STALL > BR_LOAD_STALL) ? LOADUSE_STALL : BR_LOAD_STALL;
  localparam int unsigned MAX_ALL      = (MAX_LB > BR_ALU_STALL) ? MAX_LB : BR_ALU_STALL;
  localparam int unsigned MAX_STALL    = (MAX_ALL > 1) ? MAX_ALL : 1;
  localparam int unsigned CNT_W        = $clog2(MAX_STALL) + 1;

  localparam bit LU_EN  = (LOADUSE_STALL != 0);
  localparam bit BA_EN  = (BR_ALU_STALL != 0);
  localparam bit BL_EN  = (BR_LOAD_STALL != 0);
  localparam bit BLM_EN = (BR_MEM_STALL != 0);

  typedef enum logic { IDLE, STALL } state_t;
  typedef enum logic [1:0] {
    SRC_NONE     = 2'd0,
    SRC_LOAD_USE = 2'd1,
    SRC_BR_ALU   = 2'd2,
    SRC_BR_LOAD  = 2'd3
  } src_t;

  state_t           state;
  src_t             src_q;
  logic [CNT_W-1:0] cnt;

  logic             exm;
  logic             memm;
  src_t             det_src;
  logic [CNT_W-1:0] det_n;
  logic             flush_i;
  logic             wen_i;
  logic             delay_i;
  logic [1:0]       src_i;

  // Register 0 is hardwired, so it never creates a dependency
  assign exm  = (ex_rd != '0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign memm = (mem_rd != '0) && ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

  // Priority hazard classification; a class with a zero stall length is treated as absent
  always_comb begin
    det_src = SRC_NONE;
    det_n   = '0;
    if (BL_EN && id_branch && ex_mem_read && exm) begin
      det_src = SRC_BR_LOAD;
      det_n   = CNT_W'(BR_LOAD_STALL);
    end else if (BLM_EN && id_branch && mem_mem_read && memm) begin
      det_src = SRC_BR_LOAD;
      det_n   = CNT_W'(BR_MEM_STALL);
    end else if (BA_EN && id_branch && ex_reg_write && !ex_mem_read && exm) begin
      det_src = SRC_BR_ALU;
      det_n   = CNT_W'(BR_ALU_STALL);
    end else if (LU_EN && !id_branch && ex_mem_read && exm) begin
      det_src = SRC_LOAD_USE;
      det_n   = CNT_W'(LOADUSE_STALL);
    end
  end

  // Zero-latency pipeline controls; a taken branch squashes the stalled instruction
  always_comb begin
    flush_i = branching;
    wen_i   = 1'b1;
    delay_i = 1'b0;
    src_i   = SRC_NONE;
    if (!branching) begin
      if (state == STALL) begin
        wen_i   = 1'b0;
        delay_i = 1'b1;
        src_i   = src_q;
      end else if (det_src != SRC_NONE) begin
        wen_i   = 1'b0;
        delay_i = 1'b1;
        src_i   = det_src;
      end
    end
  end

  assign flush     = rst_n & flush_i;
  assign wen       = ~rst_n | wen_i;
  assign delay     = rst_n & delay_i;
  assign stall_src = rst_n ? src_i : 2'd0;

  // Stall sequencer: the detection cycle is the first of N stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      src_q <= SRC_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (!branching && (det_src != SRC_NONE) && (det_n > CNT_W'(1))) begin
            state <= STALL;
            cnt   <= det_n - CNT_W'(1);
            src_q <= det_src;
          end
        end
        STALL: begin
          if (branching || (cnt == CNT_W'(1))) begin
            state <= IDLE;
            cnt   <= '0;
            src_q <= SRC_NONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          src_q <= SRC_NONE;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_q;
  logic [STAT_W-1:0] flush_q;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (delay_i && (stall_q != '1)) stall_q <= stall_q + STAT_W'(1);
      if (flush_i && (flush_q != '1)) flush_q <= flush_q + STAT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline; sits beside the ID stage and drives PC/IF-ID write enable, ID/EX bubble insertion and IF/ID flush.
- Adds multi-cycle stall sequencing via a registered counter/FSM.
- Distinguishes load-use, ALU-to-branch and load-to-branch hazards, each with a parametrised stall length.
- Register-address width is parametrised.

Parameters:
- REG_ADDR_W, 5, register specifier width.
- LOADUSE_STALL, 1, stall cycles for a load feeding a non-branch ID instruction (0 = class disabled).
- BR_ALU_STALL, 1, stall cycles for an ALU result in EX feeding a branch in ID (0 = disabled).
- BR_LOAD_STALL, 2, stall cycles for a load in EX feeding a branch in ID (0 = disabled); a load in MEM feeding a branch always costs min(1, BR_LOAD_STALL).
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- branching  input  1  branch resolved taken this cycle.
- id_branch  input  1  ID instruction is a branch (compares in ID).
- id_uses_rt  input  1  ID instruction reads rt.
- id_rs  input  REG_ADDR_W  ID source register rs.
- id_rt  input  REG_ADDR_W  ID source register rt.
- ex_mem_read  input  1  EX instruction is a load.
- ex_reg_write  input  1  EX instruction writes a register.
- ex_rd  input  REG_ADDR_W  EX destination register.
- mem_mem_read  input  1  MEM instruction is a load.
- mem_rd  input  REG_ADDR_W  MEM destination register.
- flush  output  1  squash IF/ID.
- wen  output  1  PC and IF/ID write enable; 0 = hold.
- delay  output  1  insert bubble into ID/EX.
- stall_src  output  2  cause of the current stall: 0 none, 1 load-use, 2 branch-ALU, 3 branch-load.
- stall_cycles  output  STAT_W  total stalled cycles (see Optional Feature).
- flush_count  output  STAT_W  total flush cycles (see Optional Feature).

Behaviour:
- Reset: async on rst_n low. State IDLE, counter 0, stall_src 0, stats 0. While rst_n low, outputs are forced to flush=0, wen=1, delay=0.
- Match rules:
  - exm = ex_rd!=0 and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)).
  - memm is the same rule using mem_rd.
  - Register 0 never causes a hazard.
- Hazard classes, evaluated only in IDLE, highest priority first:
  - Branch-load: id_branch & ex_mem_read & exm -> N=BR_LOAD_STALL.
  - Branch-load (MEM): id_branch & mem_mem_read & memm -> N=min(1,BR_LOAD_STALL).
  - Branch-ALU: id_branch & ex_reg_write & !ex_mem_read & exm -> N=BR_ALU_STALL.
  - Load-use: !id_branch & ex_mem_read & exm -> N=LOADUSE_STALL.
  - A class with N=0 does not match.
- Stall outputs: wen=0, delay=1 in the same cycle the hazard is detected (combinational, zero latency). stall_src shows the class.
- Stall sequencing:
  - If N>1, counter loads N-1 and the FSM moves to STALL.
  - In STALL: wen=0, delay=1, stall_src held; counter decrements each cycle.
  - When counter==1 the FSM returns to IDLE on the next edge.
  - Total stall is exactly N consecutive cycles. No re-evaluation of hazards during STALL.
- flush: flush = branching, combinational, in any state.
- Branching priority: branching=1 overrides any stall. delay=0, wen=1 that cycle; counter is cleared and the FSM goes to IDLE on the next edge. The stalled ID instruction is being squashed.
- Back-to-back hazards: a new hazard detected in the first IDLE cycle after a STALL starts a fresh sequence.
- Counter width: clog2 of the maximum stall parameter, plus 1. No wrap is possible.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_cycles increments on every cycle with delay=1.
  - flush_count increments on every cycle with flush=1.
  - Both saturate at all-ones and are cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_branch=0 -> delay=1, wen=0, stall_src=1 for exactly 1 cycle, then wen=1.
- Branch-load: ex_mem_read=1, ex_rd=9, id_branch=1, id_rt=9, id_uses_rt=1 -> 2 consecutive stall cycles with stall_src=3, then IDLE.
- Reg zero and disable: ex_rd=0 matching id_rs=0 -> no stall. Then BR_ALU_STALL=0 with an ALU-to-branch match -> no stall.
- Flush abort: branch-load stall in progress, branching=1 on the 2nd cycle -> flush=1, delay=0, wen=1 that cycle; IDLE next cycle.
- Reset mid-stall: rst_n low during STALL -> outputs immediately flush=0, wen=1, delay=0. After release, no residual stall.
- HAZARD_STATS_EN defined: 3 load-use stalls plus 2 flush cycles -> stall_cycles=3, flush_count=2. With STAT_W=2, saturation holds at 3.
